// File: rtl/received_frame_generator.sv
// received_frame_generator
// Drives NG_NUM symbol generators through one shared clock-enable and collects
// their quantised messages into N-symbol frames on a valid/ready master port.
// When the output buffer is still occupied at the end of a frame, the FSM parks
// in HOLD with sym_ce low. The generator pipelines freeze rather than flush.
// Optional build macro: RXGEN_FRAME_TAG_EN adds a wrapping frame counter and the
// frame_id output.
module received_frame_generator #(
    parameter int N              = 204,
    parameter int NG_NUM         = 4,
    parameter int NG_SIZE        = N / NG_NUM,
    parameter int QUAN_SIZE      = 4,
    parameter int PIPELINE_DELAY = 24,
    parameter int SIGMA_W        = 16,
    parameter int FRAME_CNT_W    = 16
) (
    input  logic                        sys_clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [SIGMA_W-1:0]          sigma_in,
    input  logic [NG_NUM*QUAN_SIZE-1:0] sym_in,
    output logic                        sym_ce,
    output logic [SIGMA_W-1:0]          sigma_out,
    output logic [N*QUAN_SIZE-1:0]      m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        busy
`ifdef RXGEN_FRAME_TAG_EN
    ,
    output logic [FRAME_CNT_W-1:0]      frame_id
`endif
);

    localparam int SEG_W  = NG_SIZE * QUAN_SIZE;
    localparam int WARM_W = $clog2(PIPELINE_DELAY + 1);
    localparam int CNT_W  = $clog2(NG_SIZE + 1);

    // Reject parameter sets that cannot split the frame evenly or have no latency.
    if ((N % NG_NUM) != 0 || (NG_SIZE * NG_NUM) != N) begin : g_bad_split
        $error("received_frame_generator: N must be NG_NUM * NG_SIZE");
    end
    if (PIPELINE_DELAY < 1) begin : g_bad_delay
        $error("received_frame_generator: PIPELINE_DELAY must be >= 1");
    end
    if (FRAME_CNT_W < 1) begin : g_bad_cnt_w
        $error("received_frame_generator: FRAME_CNT_W must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, WARMUP, FILL, HOLD} state_t;

    state_t                          state_q, state_d;
    logic [WARM_W-1:0]               warm_cnt_q;
    logic [CNT_W-1:0]                sym_cnt_q;
    logic [NG_NUM-1:0][SEG_W-1:0]    asm_q;
    logic [NG_NUM-1:0][SEG_W-1:0]    asm_shift;
    logic [NG_NUM-1:0][SEG_W-1:0]    load_word;
    logic [N*QUAN_SIZE-1:0]          m_data_q;
    logic                            m_valid_q;
    logic [SIGMA_W-1:0]              sigma_q;
    logic                            buf_free;
    logic                            last_fill;
    logic                            load_fill;
    logic                            load_hold;
    logic                            load;

    // Each segment shifts left and appends its own generator slice, so the first
    // captured symbol ends up at the segment MSBs.
    for (genvar gi = 0; gi < NG_NUM; gi++) begin : g_seg
        if (NG_SIZE == 1) begin : g_single
            assign asm_shift[gi] = sym_in[gi*QUAN_SIZE +: QUAN_SIZE];
        end else begin : g_multi
            assign asm_shift[gi] = {asm_q[gi][SEG_W-QUAN_SIZE-1:0],
                                    sym_in[gi*QUAN_SIZE +: QUAN_SIZE]};
        end
    end

    assign buf_free  = !m_valid_q || m_ready;
    assign last_fill = (state_q == FILL) && (sym_cnt_q == CNT_W'(NG_SIZE - 1));
    assign load_fill = last_fill && buf_free;
    assign load_hold = (state_q == HOLD) && buf_free;
    assign load      = load_fill || load_hold;
    // A load from FILL must include the symbol arriving this cycle.
    assign load_word = load_fill ? asm_shift : asm_q;

    // State register.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic. A started frame always completes, whatever en does.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = WARMUP;
            WARMUP:  if (warm_cnt_q == WARM_W'(PIPELINE_DELAY - 1)) state_d = FILL;
            FILL:    if (last_fill) state_d = buf_free ? (en ? FILL : IDLE) : HOLD;
            HOLD:    if (buf_free) state_d = en ? FILL : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state: generators only advance in WARMUP and FILL.
    always_comb begin
        sym_ce = 1'b0;
        busy   = 1'b0;
        if (state_q == WARMUP || state_q == FILL) sym_ce = 1'b1;
        if (state_q != IDLE)                      busy   = 1'b1;
    end

    // Warm-up and symbol counters; both rest at zero outside their state.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            warm_cnt_q <= '0;
            sym_cnt_q  <= '0;
        end else begin
            warm_cnt_q <= (state_q == WARMUP) ? warm_cnt_q + WARM_W'(1) : '0;
            if (state_q == FILL && !last_fill) sym_cnt_q <= sym_cnt_q + CNT_W'(1);
            else                               sym_cnt_q <= '0;
        end
    end

    // Assembly registers capture in FILL and hold their value through HOLD.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst)                   asm_q <= '0;
        else if (state_q == FILL)  asm_q <= asm_shift;
    end

    // Output buffer: load when free, drop valid on acceptance without a reload.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
        end else if (load) begin
            m_data_q  <= load_word;
            m_valid_q <= 1'b1;
        end else if (m_ready) begin
            m_valid_q <= 1'b0;
        end
    end

    // Sigma is latched only when a run starts.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst)                       sigma_q <= '0;
        else if (state_q == IDLE && en) sigma_q <= sigma_in;
    end

`ifdef RXGEN_FRAME_TAG_EN
    logic [FRAME_CNT_W-1:0] frame_cnt_q;
    logic [FRAME_CNT_W-1:0] frame_id_q;

    // Tag each loaded frame; the counter survives IDLE and wraps naturally.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            frame_id_q  <= '0;
        end else if (load) begin
            frame_id_q  <= frame_cnt_q;
            frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
        end
    end

    assign frame_id = frame_id_q;
`endif

    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign sigma_out = sigma_q;

endmodule

// File: tb/tb_received_frame_generator.sv
// Bench for received_frame_generator with N=8, NG_NUM=2, PIPELINE_DELAY=3.
// Generator model: slice i = (ce-count + 8*i) mod 16. Expected frames are pushed
// when a run starts and popped on every output handshake.
module tb_received_frame_generator;

    localparam int TN   = 8;
    localparam int TNG  = 2;
    localparam int TNGS = TN / TNG;
    localparam int TQ   = 4;
    localparam int TPD  = 3;
    localparam int TSW  = 16;

    logic                clk;
    logic                rst;
    logic                en;
    logic [TSW-1:0]      sigma_in;
    logic [TNG*TQ-1:0]   sym_in;
    logic                sym_ce;
    logic [TSW-1:0]      sigma_out;
    logic [TN*TQ-1:0]    m_data;
    logic                m_valid;
    logic                m_ready;
    logic                busy;
`ifdef RXGEN_FRAME_TAG_EN
    logic [15:0]         frame_id;
    logic                sym_ce2;
    logic [TSW-1:0]      sigma2;
    logic [TN*TQ-1:0]    data2;
    logic                valid2;
    logic                busy2;
    logic [1:0]          id2;
`endif

    received_frame_generator #(
        .N(TN), .NG_NUM(TNG), .NG_SIZE(TNGS), .QUAN_SIZE(TQ),
        .PIPELINE_DELAY(TPD), .SIGMA_W(TSW), .FRAME_CNT_W(16)
    ) dut (
        .sys_clk(clk), .rst(rst), .en(en), .sigma_in(sigma_in), .sym_in(sym_in),
        .sym_ce(sym_ce), .sigma_out(sigma_out), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .busy(busy)
`ifdef RXGEN_FRAME_TAG_EN
        , .frame_id(frame_id)
`endif
    );

`ifdef RXGEN_FRAME_TAG_EN
    // Narrow-tag copy sharing all inputs, used to observe counter wrap.
    received_frame_generator #(
        .N(TN), .NG_NUM(TNG), .NG_SIZE(TNGS), .QUAN_SIZE(TQ),
        .PIPELINE_DELAY(TPD), .SIGMA_W(TSW), .FRAME_CNT_W(2)
    ) dut_wrap (
        .sys_clk(clk), .rst(rst), .en(en), .sigma_in(sigma_in), .sym_in(sym_in),
        .sym_ce(sym_ce2), .sigma_out(sigma2), .m_data(data2), .m_valid(valid2),
        .m_ready(m_ready), .busy(busy2), .frame_id(id2)
    );
`endif

    typedef struct {
        logic [TN*TQ-1:0] data;
        int               id;
    } frame_t;

    frame_t sb_q[$];
    frame_t mon_e;
    int     n_checks = 0;
    int     n_pass   = 0;
    int     tag_cnt  = 0;
    int     ce_cnt   = 0;
    int     cur      = 0;
    int     n_frames = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generator model: advances once per ce-high clock.
    always @(posedge clk or posedge rst) begin
        if (rst)         ce_cnt <= 0;
        else if (sym_ce) ce_cnt <= ce_cnt + 1;
    end

    always_comb begin
        sym_in = '0;
        for (int i = 0; i < TNG; i++) sym_in[i*TQ +: TQ] = 4'((ce_cnt + 8*i) % 16);
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Frame whose first symbol is generator output number s.
    function automatic logic [TN*TQ-1:0] exp_frame(input int s);
        logic [TN*TQ-1:0] w;
        w = '0;
        for (int i = 0; i < TNG; i++)
            for (int t = 0; t < TNGS; t++)
                w[i*TNGS*TQ + (TNGS-1-t)*TQ +: TQ] = 4'((s + t + 8*i) % 16);
        return w;
    endfunction

    // Called while idle: every captured symbol uses exactly one ce-high cycle,
    // the first PIPELINE_DELAY of the run being discarded.
    task automatic push_frames(input int n);
        int s;
        s = ce_cnt + TPD;
        for (int j = 0; j < n; j++) begin
            sb_q.push_back('{data: exp_frame(s + j*TNGS), id: tag_cnt});
            tag_cnt++;
        end
    endtask

    // Advance to 1 time unit after run-relative edge e.
    task automatic go_to(input int e);
        while (cur < e) begin
            @(posedge clk);
            cur++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb_q.delete();
        tag_cnt = 0;
    endtask

    // Scoreboard monitor: one line per accepted frame.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_underflow", 64'(sb_q.size()), 64'd1);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("frame_data", 64'(m_data), 64'(mon_e.data));
`ifdef RXGEN_FRAME_TAG_EN
                check_eq("frame_id", 64'(frame_id), 64'(mon_e.id));
                check_eq("wrap_valid", 64'(valid2), 64'd1);
                check_eq("wrap_data", 64'(data2), 64'(mon_e.data));
                check_eq("wrap_id", 64'(id2), 64'(mon_e.id % 4));
`endif
                $display("frame %0d accepted data=%h exp_id=%0d", n_frames, m_data, mon_e.id);
                n_frames++;
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; m_ready = 1'b0; sigma_in = '0;
        do_reset();
        check_eq("rst_valid", 64'(m_valid), 64'd0);
        check_eq("rst_data", 64'(m_data), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_ce", 64'(sym_ce), 64'd0);
        check_eq("rst_sigma", 64'(sigma_out), 64'd0);

        // Startup and steady state, then stop after the fifth frame.
        sigma_in = 16'hA5A5; m_ready = 1'b1;
        push_frames(5);
        en = 1'b1; cur = -1;
        for (int e = 0; e <= 23; e++) begin
            go_to(e);
            check_eq("a_ce", 64'(sym_ce), 64'(e <= 22));
            check_eq("a_valid", 64'(m_valid), 64'(e >= 7 && ((e - 7) % 4) == 0));
            if (e == 0) begin
                check_eq("a_sigma", 64'(sigma_out), 64'hA5A5);
`ifdef RXGEN_FRAME_TAG_EN
                check_eq("a_wrap_ce", 64'(sym_ce2), 64'd1);
                check_eq("a_wrap_busy", 64'(busy2), 64'd1);
                check_eq("a_wrap_sigma", 64'(sigma2), 64'hA5A5);
`endif
            end
            if (e == 7) check_eq("a_first_frame", 64'(m_data), 64'hBCDE3456);
            if (e == 20) en = 1'b0;
        end
        go_to(24);
        check_eq("a_busy_end", 64'(busy), 64'd0);
        check_eq("a_sb_empty", 64'(sb_q.size()), 64'd0);

        // Stop mid-frame, then restart with a new sigma.
        sigma_in = 16'h1234;
        push_frames(2);
        en = 1'b1; cur = -1;
        go_to(0);
        check_eq("b_sigma1", 64'(sigma_out), 64'h1234);
        go_to(8);  en = 1'b0;
        go_to(11); check_eq("b_valid", 64'(m_valid), 64'd1);
        go_to(12);
        check_eq("b_busy", 64'(busy), 64'd0);
        check_eq("b_ce", 64'(sym_ce), 64'd0);
        check_eq("b_valid_off", 64'(m_valid), 64'd0);
        sigma_in = 16'hBEEF;
        push_frames(1);
        en = 1'b1; cur = -1;
        go_to(0);  check_eq("b_sigma2", 64'(sigma_out), 64'hBEEF);
        go_to(1);  en = 1'b0;
        go_to(3);  check_eq("b_rewarm_ce", 64'(sym_ce), 64'd1);
        go_to(6);  check_eq("b_valid6", 64'(m_valid), 64'd0);
        go_to(7);  check_eq("b_valid7", 64'(m_valid), 64'd1);
        go_to(8);
        check_eq("b_busy_end", 64'(busy), 64'd0);
        check_eq("b_sb_empty", 64'(sb_q.size()), 64'd0);

        // Back-pressure: m_ready sampled low on edges 6..20.
        do_reset();
        m_ready = 1'b1;
        push_frames(3);
        en = 1'b1; cur = -1;
        go_to(5);  m_ready = 1'b0;
        go_to(7);  check_eq("c_frame1", 64'(m_data), 64'hBCDE3456);
        for (int e = 11; e <= 20; e++) begin
            go_to(e);
            check_eq("c_hold_ce", 64'(sym_ce), 64'd0);
            check_eq("c_hold_busy", 64'(busy), 64'd1);
            check_eq("c_hold_valid", 64'(m_valid), 64'd1);
            check_eq("c_hold_data", 64'(m_data), 64'hBCDE3456);
            if (e == 20) m_ready = 1'b1;
        end
        go_to(21);
        check_eq("c_zero_bubble", 64'(m_valid), 64'd1);
        check_eq("c_frame2", 64'(m_data), 64'hF012789A);
        check_eq("c_resume_ce", 64'(sym_ce), 64'd1);
        go_to(22); en = 1'b0;
        go_to(25); check_eq("c_frame3_valid", 64'(m_valid), 64'd1);
        go_to(26);
        check_eq("c_busy_end", 64'(busy), 64'd0);
        check_eq("c_sb_empty", 64'(sb_q.size()), 64'd0);

        // Asynchronous reset in the middle of the second frame.
        do_reset();
        m_ready = 1'b1;
        push_frames(1);
        en = 1'b1; cur = -1;
        go_to(9);
        rst = 1'b1;
        #1;
        check_eq("d_rst_valid", 64'(m_valid), 64'd0);
        check_eq("d_rst_data", 64'(m_data), 64'd0);
        check_eq("d_rst_busy", 64'(busy), 64'd0);
        check_eq("d_rst_ce", 64'(sym_ce), 64'd0);
        check_eq("d_rst_sigma", 64'(sigma_out), 64'd0);
        check_eq("d_sb_pre_rst", 64'(sb_q.size()), 64'd0);
        #1 rst = 1'b0;
        sb_q.delete();
        tag_cnt = 0;
        push_frames(1);
        cur = -1;
        go_to(1);  en = 1'b0;
        go_to(6);  check_eq("d_valid6", 64'(m_valid), 64'd0);
        go_to(7);
        check_eq("d_valid7", 64'(m_valid), 64'd1);
        check_eq("d_frame", 64'(m_data), 64'hBCDE3456);
        go_to(8);
        check_eq("d_busy_end", 64'(busy), 64'd0);
        check_eq("d_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
